// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing defaults, derived totals and coordinate type
package vga_timing_pkg;

  localparam int DIV_DEFAULT = 4;

  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SW    = 96;
  localparam int H_BP    = 48;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SW    = 2;
  localparam int V_BP    = 33;

  localparam int H_TOTAL      = H_DISP + H_FP + H_SW + H_BP;
  localparam int V_TOTAL      = V_DISP + V_FP + V_SW + V_BP;
  localparam int H_SYNC_START = H_DISP + H_FP;
  localparam int H_SYNC_END   = H_DISP + H_FP + H_SW - 1;
  localparam int V_SYNC_START = V_DISP + V_FP;
  localparam int V_SYNC_END   = V_DISP + V_FP + V_SW - 1;

  localparam int COORD_LIMIT = 1024;

  typedef logic [9:0] pix_coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - timing outputs bundle from vga_sync_gen to the graphics path and pins
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic       p_tick;
  pix_coord_t pix_x;
  pix_coord_t pix_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick);
  modport slave  (input  p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick);

endinterface

// File: rtl/vga_tick_div.sv
// rtl/vga_tick_div.sv - pixel enable divider: one clk-wide p_tick every DIV clocks
module vga_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("vga_tick_div: DIV must be at least 2");
  end

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA h/v counters and sync/active decode; VGA_SYNC_REG_EN registers the decodes
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV      = DIV_DEFAULT,
  parameter int HD       = H_DISP,
  parameter int HFP      = H_FP,
  parameter int HSW      = H_SW,
  parameter int HBP      = H_BP,
  parameter int VD       = V_DISP,
  parameter int VFP      = V_FP,
  parameter int VSW      = V_SW,
  parameter int VBP      = V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  vga_sync_if.master vga
);

  localparam int HTOT = HD + HFP + HSW + HBP;
  localparam int VTOT = VD + VFP + VSW + VBP;

  localparam pix_coord_t H_LAST   = pix_coord_t'(HTOT - 1);
  localparam pix_coord_t V_LAST   = pix_coord_t'(VTOT - 1);
  localparam pix_coord_t H_ACT    = pix_coord_t'(HD);
  localparam pix_coord_t V_ACT    = pix_coord_t'(VD);
  localparam pix_coord_t HS_FIRST = pix_coord_t'(HD + HFP);
  localparam pix_coord_t HS_LAST  = pix_coord_t'(HD + HFP + HSW - 1);
  localparam pix_coord_t VS_FIRST = pix_coord_t'(VD + VFP);
  localparam pix_coord_t VS_LAST  = pix_coord_t'(VD + VFP + VSW - 1);

  if (HTOT > COORD_LIMIT || VTOT > COORD_LIMIT) begin : g_bad_total
    $error("vga_sync_gen: HTOT and VTOT must not exceed 1024");
  end

  logic       p_tick;
  pix_coord_t h_cnt, v_cnt;
  pix_coord_t h_nxt, v_nxt;

  vga_tick_div #(.DIV(DIV)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Corner (H_LAST, V_LAST) wraps both counters to (0,0) on one edge
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (p_tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Returns {video_on, hsync, vsync} for a counter pair
  function automatic logic [2:0] decode(pix_coord_t h, pix_coord_t v);
    logic von, hs, vs;
    von = (h < H_ACT) && (v < V_ACT);
    hs  = (h >= HS_FIRST && h <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vs  = (v >= VS_FIRST && v <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    return {von, hs, vs};
  endfunction

`ifdef VGA_SYNC_REG_EN
  logic video_on_q, hsync_q, vsync_q;

  // Loading from the next-state counters keeps zero latency versus pix_x/pix_y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_on_q <= 1'b1;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
    end else begin
      {video_on_q, hsync_q, vsync_q} <= decode(h_nxt, v_nxt);
    end
  end

  assign vga.video_on = video_on_q;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
`else
  assign {vga.video_on, vga.hsync, vga.vsync} = decode(h_cnt, v_cnt);
`endif

  assign vga.p_tick     = p_tick;
  assign vga.pix_x      = h_cnt;
  assign vga.pix_y      = v_cnt;
  assign vga.frame_tick = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized-reset bench comparing two vga_sync_gen configurations to a time-based model
module tb_vga_sync_gen;

  typedef struct {
    int div, hd, hfp, hsw, hbp, vd, vfp, vsw, vbp;
    bit pol;
  } cfg_t;

  typedef struct {
    logic p_tick;
    int   x, y;
    logic von, hs, vs, ft;
  } exp_t;

  logic   clk;
  logic   rst;
  longint c;        // rising edges since reset release
  longint gcyc;     // rising edges since time zero
  longint last_ft;
  int     vectors;
  int     miscompares;
  cfg_t   dcfg, scfg;

  vga_sync_if d_if ();
  vga_sync_if s_if ();

  vga_sync_gen u_dut (
    .clk   (clk),
    .reset (rst),
    .vga   (d_if)
  );

  vga_sync_gen #(
    .DIV(3), .HD(8), .HFP(2), .HSW(3), .HBP(2),
    .VD(5), .VFP(1), .VSW(2), .VBP(2), .SYNC_POL(1'b1)
  ) u_small (
    .clk   (clk),
    .reset (rst),
    .vga   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after c clock edges: pixel index is c/DIV, position within the frame follows
  function automatic exp_t model(cfg_t k, longint cyc);
    exp_t   e;
    longint n, pos;
    int     htot, vtot;
    htot     = k.hd + k.hfp + k.hsw + k.hbp;
    vtot     = k.vd + k.vfp + k.vsw + k.vbp;
    n        = cyc / k.div;
    pos      = n % (htot * vtot);
    e.x      = int'(pos % htot);
    e.y      = int'(pos / htot);
    e.p_tick = (cyc % k.div) == longint'(k.div - 1);
    e.von    = (e.x < k.hd) && (e.y < k.vd);
    e.hs     = (e.x >= k.hd + k.hfp && e.x < k.hd + k.hfp + k.hsw) ? k.pol : !k.pol;
    e.vs     = (e.y >= k.vd + k.vfp && e.y < k.vd + k.vfp + k.vsw) ? k.pol : !k.pol;
    e.ft     = e.p_tick && (pos == longint'(htot * vtot - 1));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, gcyc, obs, exp);
    end
  endtask

  task automatic check_inst(input string name, input cfg_t k, input logic pt,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic von, input logic hs, input logic vs, input logic ft);
    exp_t e;
    e = model(k, c);
    chk({name, ".p_tick"},     32'(pt),  32'(e.p_tick));
    chk({name, ".pix_x"},      32'(x),   32'(e.x));
    chk({name, ".pix_y"},      32'(y),   32'(e.y));
    chk({name, ".video_on"},   32'(von), 32'(e.von));
    chk({name, ".hsync"},      32'(hs),  32'(e.hs));
    chk({name, ".vsync"},      32'(vs),  32'(e.vs));
    chk({name, ".frame_tick"}, 32'(ft),  32'(e.ft));
  endtask

  task automatic check_both();
    check_inst("dflt", dcfg, d_if.p_tick, d_if.pix_x, d_if.pix_y,
               d_if.video_on, d_if.hsync, d_if.vsync, d_if.frame_tick);
    check_inst("small", scfg, s_if.p_tick, s_if.pix_x, s_if.pix_y,
               s_if.video_on, s_if.hsync, s_if.vsync, s_if.frame_tick);
    if (!rst && s_if.frame_tick === 1'b1) begin
      if (last_ft >= 0)
        chk("small.frame_period", 32'(gcyc - last_ft),
            32'(scfg.div * (scfg.hd + scfg.hfp + scfg.hsw + scfg.hbp)
                         * (scfg.vd + scfg.vfp + scfg.vsw + scfg.vbp)));
      last_ft = gcyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    gcyc++;
    if (!rst) c++;
    @(negedge clk);
    check_both();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (miscompares > 40) break;
      step();
    end
  endtask

  // Reset lands between edges so the asynchronous clear is checked before any clock
  task automatic mid_reset();
    #($urandom_range(1, 3));
    rst     = 1'b1;
    c       = 0;
    last_ft = -1;
    #1;
    check_both();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    dcfg        = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    scfg        = '{3, 8, 2, 3, 2, 5, 1, 2, 2, 1'b1};
    rst         = 1'b1;
    c           = 0;
    gcyc        = 0;
    last_ft     = -1;
    vectors     = 0;
    miscompares = 0;
    @(negedge clk);
    check_both();
    step();
    step();
    rst = 1'b0;
    run(3400);
    for (int i = 0; i < 8; i++) begin
      if (miscompares > 40) break;
      mid_reset();
      run(int'($urandom_range(300, 7000)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
